regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Parametrised register file: one write port, two independent read ports, synchronous reads, byte-granular write enables.
- Next generation of the team's 8x16 single-port register file, sized for the datapath's operand-fetch stage (two source operands read per cycle, one result written back).
- Reads and writes may occur in the same cycle.
- Same-address read-after-write is forwarded in the same cycle.

Parameters:
- WIDTH, 16, data width in bits; must be a multiple of 8.
- DEPTH, 8, number of entries; need not be a power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), address width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- WrEn  input  1  write request.
- WrAddr  input  ADDR_W  write address.
- WrData  input  WIDTH  write data.
- WrBe  input  WIDTH/8  byte enables; bit i covers WrData[8i+7:8i].
- RdEn0  input  1  read request, port 0.
- RdAddr0  input  ADDR_W  read address, port 0.
- RdData0  output  WIDTH  registered read data, port 0.
- RdValid0  output  1  RdData0 updated this cycle.
- RdErr0  output  1  port 0 read address was out of range.
- RdEn1, RdAddr1, RdData1, RdValid1, RdErr1: identical set for port 1.
- WrErr  output  1  registered; previous-cycle write address was out of range.

Behaviour:
- Reset (RST=1 at a rising edge):
  - All DEPTH entries cleared to 0.
  - RdData0/1 = 0; RdValid0/1 = 0; RdErr0/1 = 0; WrErr = 0.
  - Reset overrides every request in that cycle; a write presented with RST=1 is lost.
- Write:
  - Condition: WrEn=1 and WrAddr<DEPTH.
  - Effect: entry[WrAddr] byte i <= WrData byte i for each WrBe[i]=1; other bytes hold.
  - WrBe=0 with WrEn=1 is a legal no-op.
- Write out of range (WrAddr>=DEPTH):
  - Array unchanged.
  - WrErr=1 the next cycle, for one cycle per offending write.
- Read, per port independently:
  - Latency: 1 cycle. RdEn sampled at edge N gives RdData and RdValid=1 after edge N.
  - RdEn=0: RdData holds its last value; RdValid=0; RdErr=0.
- Read out of range (RdAddr>=DEPTH):
  - RdData=0, RdValid=1, RdErr=1.
- Same-cycle bypass (write-first):
  - Condition: RdEn=1, WrEn=1, RdAddr==WrAddr, address in range.
  - Enabled bytes of RdData come from WrData; disabled bytes come from the stored entry.
  - Result equals what a read issued the following cycle would return.
- Both ports reading the same address is legal; both return identical data.
- Back-to-back reads and writes every cycle supported; no stall, no backpressure.
- No FSM. State is the array plus the output registers.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Entry 0 is hardwired to zero; writes to address 0 are discarded (WrErr stays 0).
  - Reads of address 0 return 0, including under the bypass condition.
  - Storage for entry 0 must not be synthesised.
- Undefined: entry 0 is an ordinary entry.

Test Plan:
- Reset then read all addresses on both ports -> every RdData=0x0000 with RdValid=1 one cycle after each RdEn.
- Write 0xA5C3 to addr 3 with WrBe=2'b11, then write 0x11FF to addr 3 with WrBe=2'b01, then read addr 3 -> 0xA5FF.
- Same cycle: write 0x1234 to addr 5 (WrBe=2'b10), port 0 reads addr 5 (old value 0xBEEF), port 1 reads addr 2 (holds 0x0042) -> next cycle RdData0=0x12EF, RdData1=0x0042.
- DEPTH=6: write to addr 7 and read addr 6 on port 1 -> WrErr=1 for one cycle, RdData1=0, RdErr1=1, entries 0-5 unchanged.
- Assert RST while WrEn=1 to addr 1 with RdEn0=1 -> after the edge RdValid0=0, RdData0=0; a subsequent read of addr 1 returns 0.
- With REGFILE_ZERO_REG_EN: write 0xFFFF to addr 0 while port 0 reads addr 0 -> RdData0=0x0000, WrErr=0. Without the macro -> RdData0=0xFFFF via bypass.

Source files
------------

// File: rtl/regfile_2r1w_if.sv
// Operand-fetch register file bus: one byte-masked write port and two read ports.
// The master drives requests; the slave (the register file) returns read data and error flags.
interface regfile_2r1w_if #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic                 WrEn;
    logic [ADDR_W-1:0]    WrAddr;
    logic [WIDTH-1:0]     WrData;
    logic [WIDTH/8-1:0]   WrBe;
    logic                 WrErr;

    logic                 RdEn0;
    logic [ADDR_W-1:0]    RdAddr0;
    logic [WIDTH-1:0]     RdData0;
    logic                 RdValid0;
    logic                 RdErr0;

    logic                 RdEn1;
    logic [ADDR_W-1:0]    RdAddr1;
    logic [WIDTH-1:0]     RdData1;
    logic                 RdValid1;
    logic                 RdErr1;

    modport master (
        output WrEn, WrAddr, WrData, WrBe,
        output RdEn0, RdAddr0, RdEn1, RdAddr1,
        input  WrErr, RdData0, RdValid0, RdErr0, RdData1, RdValid1, RdErr1
    );

    modport slave (
        input  WrEn, WrAddr, WrData, WrBe,
        input  RdEn0, RdAddr0, RdEn1, RdAddr1,
        output WrErr, RdData0, RdValid0, RdErr0, RdData1, RdValid1, RdErr1
    );
endinterface

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file, byte write enables, write-first same-cycle bypass.
// Latency: 1 cycle on both read ports; no backpressure, a request is accepted every cycle.
// REGFILE_ZERO_REG_EN: entry 0 hardwired to zero with no storage.
module regfile_2r1w #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    regfile_2r1w_if.slave bus
);
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif
    localparam int              NBYTES  = WIDTH / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DEPTH*WIDTH-1:0] mem_flat;
    logic                   wr_in_range;
    logic                   wr_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0]  old_w,
                                               input logic [WIDTH-1:0]  new_w,
                                               input logic [NBYTES-1:0] be);
        logic [WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < NBYTES; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // Out-of-range addresses match no entry and no write, so they read as zero.
    function automatic logic [WIDTH-1:0] lookup(input logic [ADDR_W-1:0]    a,
                                                input logic [DEPTH*WIDTH-1:0] m,
                                                input logic                  wok,
                                                input logic [ADDR_W-1:0]     wa,
                                                input logic [WIDTH-1:0]      wd,
                                                input logic [NBYTES-1:0]     be);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int e = 0; e < DEPTH; e++)
            if (a == ADDR_W'(e)) r = m[e*WIDTH +: WIDTH];
        if (wok && wa == a) r = merge(r, wd, be);
        return r;
    endfunction

    assign wr_in_range = in_range(bus.WrAddr);
    assign wr_ok       = bus.WrEn && wr_in_range && !(ZERO_REG && bus.WrAddr == '0);

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        if (ZERO_REG && e == 0) begin : g_zero
            assign mem_flat[e*WIDTH +: WIDTH] = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] q;
            always_ff @(posedge CLK) begin
                if (RST)
                    q <= '0;
                else if (wr_ok && bus.WrAddr == ADDR_W'(e))
                    q <= merge(q, bus.WrData, bus.WrBe);
            end
            assign mem_flat[e*WIDTH +: WIDTH] = q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.RdData0  <= '0;
            bus.RdValid0 <= 1'b0;
            bus.RdErr0   <= 1'b0;
            bus.RdData1  <= '0;
            bus.RdValid1 <= 1'b0;
            bus.RdErr1   <= 1'b0;
            bus.WrErr    <= 1'b0;
        end else begin
            bus.WrErr    <= bus.WrEn && !wr_in_range;
            bus.RdValid0 <= bus.RdEn0;
            bus.RdErr0   <= bus.RdEn0 && !in_range(bus.RdAddr0);
            bus.RdValid1 <= bus.RdEn1;
            bus.RdErr1   <= bus.RdEn1 && !in_range(bus.RdAddr1);
            if (bus.RdEn0)
                bus.RdData0 <= lookup(bus.RdAddr0, mem_flat, wr_ok, bus.WrAddr, bus.WrData, bus.WrBe);
            if (bus.RdEn1)
                bus.RdData1 <= lookup(bus.RdAddr1, mem_flat, wr_ok, bus.WrAddr, bus.WrData, bus.WrBe);
        end
    end
endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w at DEPTH=6 (non-power-of-two, exercises out-of-range addresses).
// Expectations come from an array model updated write-first each cycle.
module tb_regfile_2r1w;
    localparam int WIDTH = 16;
    localparam int DEPTH = 6;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    regfile_2r1w_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    regfile_2r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [15:0] model [8];
    logic [15:0] e_d0 = '0, e_d1 = '0;
    logic        e_v0, e_v1, e_e0, e_e1, e_we;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic wen, input logic [2:0] wa,
                        input logic [15:0] wd, input logic [1:0] be,
                        input logic r0e, input logic [2:0] r0a,
                        input logic r1e, input logic [2:0] r1a);
        RST         = rst;
        bus.WrEn    = wen;  bus.WrAddr  = wa;  bus.WrData = wd; bus.WrBe = be;
        bus.RdEn0   = r0e;  bus.RdAddr0 = r0a;
        bus.RdEn1   = r1e;  bus.RdAddr1 = r1a;
        if (rst) begin
            for (int e = 0; e < 8; e++) model[e] = '0;
            e_d0 = '0; e_d1 = '0;
            e_v0 = 0; e_v1 = 0; e_e0 = 0; e_e1 = 0; e_we = 0;
        end else begin
            e_we = wen && (wa >= DEPTH);
            if (wen && wa < DEPTH && !(ZERO && wa == 0))
                for (int i = 0; i < 2; i++)
                    if (be[i]) model[wa][8*i +: 8] = wd[8*i +: 8];
            e_v0 = r0e; e_e0 = r0e && (r0a >= DEPTH);
            e_v1 = r1e; e_e1 = r1e && (r1a >= DEPTH);
            if (r0e) e_d0 = (r0a >= DEPTH) ? 16'h0 : model[r0a];
            if (r1e) e_d1 = (r1a >= DEPTH) ? 16'h0 : model[r1a];
        end
        @(posedge CLK);
        #1;
        chk16("rd_data0", bus.RdData0, e_d0);
        chk16("rd_data1", bus.RdData1, e_d1);
        chk1("rd_valid0", bus.RdValid0, e_v0);
        chk1("rd_valid1", bus.RdValid1, e_v1);
        chk1("rd_err0", bus.RdErr0, e_e0);
        chk1("rd_err1", bus.RdErr1, e_e1);
        chk1("wr_err", bus.WrErr, e_we);
    endtask

    initial begin
        bus.WrEn = 0; bus.WrAddr = '0; bus.WrData = '0; bus.WrBe = '0;
        bus.RdEn0 = 0; bus.RdAddr0 = '0; bus.RdEn1 = 0; bus.RdAddr1 = '0;

        // Reset, then read every address on both ports.
        step(1, 0, 0, 16'h0, 2'b00, 0, 0, 0, 0);
        for (int a = 0; a < DEPTH; a++)
            step(0, 0, 0, 16'h0, 2'b00, 1, 3'(a), 1, 3'(DEPTH - 1 - a));
        chk16("reset_read_const", bus.RdData0, 16'h0000);

        // Byte-masked overwrite.
        step(0, 1, 3, 16'hA5C3, 2'b11, 0, 0, 0, 0);
        step(0, 1, 3, 16'h11FF, 2'b01, 0, 0, 0, 0);
        step(0, 0, 0, 16'h0, 2'b00, 1, 3, 0, 0);
        chk16("byte_merge_const", bus.RdData0, 16'hA5FF);

        // Same-cycle bypass with partial byte enable.
        step(0, 1, 5, 16'hBEEF, 2'b11, 0, 0, 0, 0);
        step(0, 1, 2, 16'h0042, 2'b11, 0, 0, 0, 0);
        step(0, 1, 5, 16'h1234, 2'b10, 1, 5, 1, 2);
        chk16("bypass_d0_const", bus.RdData0, 16'h12EF);
        chk16("bypass_d1_const", bus.RdData1, 16'h0042);

        // Out-of-range write and read; WrErr pulses for a single cycle.
        step(0, 1, 7, 16'hDEAD, 2'b11, 0, 0, 1, 6);
        chk1("wr_err_const", bus.WrErr, 1'b1);
        chk1("rd_err1_const", bus.RdErr1, 1'b1);
        for (int a = 0; a < DEPTH; a++)
            step(0, 0, 0, 16'h0, 2'b00, 1, 3'(a), 1, 3'(a));

        // Reset overrides a concurrent write and read.
        step(0, 1, 1, 16'h7777, 2'b11, 0, 0, 0, 0);
        step(1, 1, 1, 16'h5555, 2'b11, 1, 1, 0, 0);
        step(0, 0, 0, 16'h0, 2'b00, 1, 1, 0, 0);
        chk16("post_reset_addr1", bus.RdData0, 16'h0000);

        // Write to address 0 while reading it on the same cycle.
        step(0, 1, 0, 16'hFFFF, 2'b11, 1, 0, 0, 0);
`ifdef REGFILE_ZERO_REG_EN
        chk16("zero_reg_const", bus.RdData0, 16'h0000);
`else
        chk16("addr0_bypass_const", bus.RdData0, 16'hFFFF);
`endif
        chk1("addr0_wr_err", bus.WrErr, 1'b0);

        // Randomized traffic across in- and out-of-range addresses.
        for (int n = 0; n < 400; n++)
            step(($urandom_range(0, 49) == 0), 1'($urandom), 3'($urandom_range(0, 7)),
                 16'($urandom), 2'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom), 3'($urandom_range(0, 7)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
